ps2_host_tx: RTL
================

# ps2_host_tx

Host-to-device PS/2 transmitter: sends one command byte (e.g. 0xED set-LEDs, 0xFF reset, 0xF4 enable) from the FPGA to the keyboard over the same two-wire bus the piano's scan-code receiver listens on. It implements the host request-to-send sequence: clock inhibit, start bit, 8 data bits LSB first, odd parity, stop and device acknowledge. It drives the open-drain lines through active-high output enables. The top level ties each enable to an open-drain pad that pulls low when the enable is 1. The receiver must ignore the bus while `busy` is high.

## Interface
- `CLK_HZ`, 50_000_000, system clock frequency (documentation only).
- `INHIBIT_CYCLES`, 5000, CLK cycles the PS/2 clock is held low (100 µs at 50 MHz).
- `TIMEOUT_CYCLES`, 750_000, CLK cycles allowed from clock release to ACK (15 ms).
- `CLK` in 1: system clock; all logic on rising edge.
- `RST` in 1: synchronous, active-high reset.
- `tx_start` in 1: request to send `tx_data`; honoured only when `ready`=1.
- `tx_data` in 8: command byte, sampled on the accepting cycle.
- `ps2c_in` in 1: PS/2 clock pad input, asynchronous.
- `ps2d_in` in 1: PS/2 data pad input, asynchronous.
- `ps2c_oe` out 1: 1 pulls the PS/2 clock low.
- `ps2d_oe` out 1: 1 pulls the PS/2 data low.
- `ready` out 1: idle and able to accept.
- `busy` out 1: equal to ~`ready`.
- `done` out 1: one-cycle pulse, frame sent and ACK received.
- `ack_err` out 1: one-cycle pulse, ACK slot sampled high.
- `timeout` out 1: one-cycle pulse, no ACK within `TIMEOUT_CYCLES`.

## Operation
- Input conditioning: `ps2c_in` and `ps2d_in` each pass through a 2-flop synchronizer. `fall` = (previous synchronized clock = 1) and (current = 0), one cycle wide.
- Parity: `par` = ~^`tx_data`, latched on accept. The shift register holds {stop=1, par, data[7:0]}.
- States:
  - `IDLE`: both enables 0; `ready`=1. On `tx_start` latch data and parity, load the counter with `INHIBIT_CYCLES`, go to `INHIBIT`.
  - `INHIBIT`: `ps2c_oe`=1, `ps2d_oe`=0. The counter decrements to 0. When it reaches 0, set `ps2d_oe`=1 (start bit), load the counter with `TIMEOUT_CYCLES`, go to `REQ`.
  - `REQ`: `ps2c_oe`=0, `ps2d_oe`=1. Bit index = 0. Go to `SEND`.
  - `SEND`: on each `fall` with bit index k in 0..9, set `ps2d_oe` = ~shift[k] and increment k. Falls 1–8 carry data, fall 9 carries parity, fall 10 carries stop, which releases data. After k reaches 10, go to `ACK`.
  - `ACK`: on the next `fall`, sample the synchronized data. 0 → `WAIT_REL`. 1 → pulse `ack_err`, go to `IDLE`.
  - `WAIT_REL`: wait until synchronized clock = 1 and synchronized data = 1, then pulse `done` and go to `IDLE`.
- Timeout: the counter decrements every cycle in `REQ`, `SEND`, `ACK` and `WAIT_REL`. On reaching 0: both enables 0, pulse `timeout`, go to `IDLE`. If timeout and ACK/completion fall on the same cycle, completion wins.
- `tx_start` while busy is ignored, with no queueing. `tx_data` is don't-care outside the accept cycle.
- Counter width: $clog2(max(INHIBIT_CYCLES, TIMEOUT_CYCLES)+1).

## Timing
- Reset values: `ps2c_oe`=0, `ps2d_oe`=0, `ready`=1, `busy`=0, `done`=0, `ack_err`=0, `timeout`=0. State = `IDLE`, counters and shift register = 0.
- `RST` mid-frame releases both lines on the same clock edge; no pulse is emitted.
- Accept at edge N:
  - `ready`=0 and `ps2c_oe`=1 from N+1.
  - `ps2c_oe` stays high exactly `INHIBIT_CYCLES` cycles.
  - `ps2d_oe` goes 1 on the last inhibit cycle, overlapping clock low by one cycle.
  - `ps2c_oe` goes 0 the following cycle.
- Data update latency: the enable changes 3 CLK cycles after the pad falling edge (2 synchronizer cycles + 1 register).
- `done`, `ack_err` and `timeout` are mutually exclusive; `ready` returns high the cycle after the pulse.

## Test plan
- Bench settings: `INHIBIT_CYCLES`=20, `TIMEOUT_CYCLES`=4000. The device model clocks at 80-cycle period, samples data on rising edges and ACKs on clock 11.
- Send 0xED: `ps2c_oe` high 20 cycles. Line bits seen by the device, with line = ~`ps2d_oe`: start 0, data 1,0,1,1,0,1,1,1, parity 1, stop 1. ACK low, then `done`=1 for one cycle; `ready`=1 afterwards.
- Send 0xF4 (parity 0) and 0x00 (parity 1): device-captured byte and parity match; `done` pulses.
- Device holds data high in the ACK slot: `ack_err` pulses once, `done` stays 0, both enables 0.
- Device never clocks: `timeout` pulses exactly 4000 cycles after clock release; both enables 0; `ready`=1.
- `RST` asserted during bit 4: the next cycle has both enables 0 and `ready`=1, with no pulse. `tx_start` while busy leaves the frame unaltered.

Source files
------------

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: request-to-send, 11-bit frame, device ACK check.
// Drives the open-drain bus through active-high enables (1 = pull line low).
module ps2_host_tx #(
    parameter int CLK_HZ         = 50_000_000,
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 750_000
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       tx_start,
    input  logic [7:0] tx_data,
    input  logic       ps2c_in,
    input  logic       ps2d_in,
    output logic       ps2c_oe,
    output logic       ps2d_oe,
    output logic       ready,
    output logic       busy,
    output logic       done,
    output logic       ack_err,
    output logic       timeout
);

    localparam int CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
    localparam int CW      = $clog2(CNT_MAX + 1);

    // The start bit must overlap the last inhibit cycle, which needs at least two cycles.
    if (CLK_HZ <= 0 || INHIBIT_CYCLES < 2 || TIMEOUT_CYCLES < 1) begin : g_bad_params
        $error("ps2_host_tx: invalid parameters");
    end

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        REQ,
        SEND,
        ACK,
        WAIT_REL
    } state_t;

    state_t        state, state_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic [9:0]    shift, shift_nx;
    logic [3:0]    bit_idx, bit_idx_nx;
    logic          d_drive, d_drive_nx;

    logic c_s1, c_s2, c_prev;
    logic d_s1, d_s2;
    logic fall;
    logic timed_state;

    // Synchronizers start at 1 (idle bus) so reset never creates a false clock fall.
    always_ff @(posedge CLK) begin
        if (RST) begin
            c_s1   <= 1'b1;
            c_s2   <= 1'b1;
            c_prev <= 1'b1;
            d_s1   <= 1'b1;
            d_s2   <= 1'b1;
        end else begin
            c_s1   <= ps2c_in;
            c_s2   <= c_s1;
            c_prev <= c_s2;
            d_s1   <= ps2d_in;
            d_s2   <= d_s1;
        end
    end

    assign fall = c_prev & ~c_s2;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state   <= IDLE;
            cnt     <= '0;
            shift   <= '0;
            bit_idx <= '0;
            d_drive <= 1'b0;
        end else begin
            state   <= state_nx;
            cnt     <= cnt_nx;
            shift   <= shift_nx;
            bit_idx <= bit_idx_nx;
            d_drive <= d_drive_nx;
        end
    end

    assign timed_state = (state == REQ) || (state == SEND) || (state == ACK) || (state == WAIT_REL);

    always_comb begin
        state_nx   = state;
        cnt_nx     = cnt;
        shift_nx   = shift;
        bit_idx_nx = bit_idx;
        d_drive_nx = d_drive;
        done       = 1'b0;
        ack_err    = 1'b0;
        timeout    = 1'b0;

        if (timed_state && cnt != '0) begin
            cnt_nx = cnt - 1'b1;
        end

        case (state)
            IDLE: begin
                d_drive_nx = 1'b0;
                if (tx_start) begin
                    shift_nx = {1'b1, ~^tx_data, tx_data};
                    cnt_nx   = CW'(INHIBIT_CYCLES);
                    state_nx = INHIBIT;
                end
            end
            INHIBIT: begin
                if (cnt <= CW'(1)) begin
                    d_drive_nx = 1'b1;
                    cnt_nx     = CW'(TIMEOUT_CYCLES);
                    state_nx   = REQ;
                end else begin
                    cnt_nx = cnt - 1'b1;
                end
            end
            REQ: begin
                bit_idx_nx = 4'd0;
                state_nx   = SEND;
            end
            SEND: begin
                if (fall) begin
                    d_drive_nx = ~shift[bit_idx];
                    bit_idx_nx = bit_idx + 4'd1;
                    if (bit_idx == 4'd9) begin
                        state_nx = ACK;
                    end
                end
            end
            ACK: begin
                if (fall) begin
                    if (d_s2) begin
                        ack_err  = 1'b1;
                        state_nx = IDLE;
                    end else begin
                        state_nx = WAIT_REL;
                    end
                end
            end
            WAIT_REL: begin
                if (c_s2 && d_s2) begin
                    done     = 1'b1;
                    state_nx = IDLE;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase

        // A completion or ACK verdict on the expiring cycle takes priority over the timeout.
        if (timed_state && cnt == '0 && !done && !ack_err) begin
            timeout    = 1'b1;
            d_drive_nx = 1'b0;
            state_nx   = IDLE;
        end
    end

    assign ps2c_oe = (state == INHIBIT);
    assign ps2d_oe = ((state == INHIBIT) && (cnt <= CW'(1))) || (d_drive && !timeout);
    assign ready   = (state == IDLE);
    assign busy    = ~ready;

endmodule
